// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word fetches and
// holds the IF/ID register that feeds decode, with redirect, stall and squash handling.
module fetch_unit #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INST_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              be_i,
  input  logic [ADDR_W-1:0] baddr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o,
  output logic              fexc_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                drop_q, drop_d;
  logic [INST_W-1:0]   skid_q, skid_d;
  logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
  logic [INST_W-1:0]   ifid_inst_q, ifid_inst_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic                fexc_q, fexc_d;
  logic                req;

  logic                redirect;
  logic                misaligned;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   pc_inc;

  // Decode operands may be stale while stalled, so a redirect only counts without stall.
  assign redirect   = be_i & ~stall_i;
  assign misaligned = |baddr_i[1:0];
  assign target     = misaligned ? RESET_PC : baddr_i;
  assign pc_inc     = pc_q + ADDR_W'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    skid_d       = skid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = stall_i ? ifid_valid_q : 1'b0;
    fexc_d       = redirect & misaligned;
    req          = 1'b0;

    if (redirect) begin
      pc_d = target;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        req     = 1'b1;
        state_d = StWait;
        // The request leaving this cycle is on the wrong path.
        if (redirect) begin
          drop_d = 1'b1;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else if (stall_i) begin
            skid_d  = imem_rdata_i;
            state_d = StHold;
          end else begin
            ifid_pc_d    = pc_q;
            ifid_inst_d  = imem_rdata_i;
            ifid_valid_d = 1'b1;
            pc_d         = pc_inc;
            state_d      = StReq;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          skid_d  = '0;
          state_d = StReq;
        end else if (!stall_i) begin
          ifid_pc_d    = pc_q;
          ifid_inst_d  = skid_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
          state_d      = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      skid_q       <= '0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= '0;
      ifid_valid_q <= 1'b0;
      fexc_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      skid_q       <= skid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      fexc_q       <= fexc_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign pc_o        = ifid_pc_q;
  assign inst_o      = ifid_inst_q;
  assign valid_o     = ifid_valid_q;
  assign fexc_o      = fexc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a driver acting as ctrl/decode and instruction memory, and a
// monitor comparing the IF/ID stream against a program-order model of the fetch path.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        be_i = 1'b0;
  logic [31:0] baddr_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        fexc_o;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .ADDR_W   (32),
    .INST_W   (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .be_i          (be_i),
    .baddr_i       (baddr_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o),
    .fexc_o        (fexc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2402_0005;
  endfunction

  // Accepted redirect targets, pushed by the driver, consumed by the monitor.
  logic [31:0] redir_q[$];
  logic [31:0] req_log[$];

  // Memory model / driver state.
  bit          pending = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          want_state = 0;
  logic [31:0] want_addr = '0;

  task automatic tick_sample(output bit saw);
    saw = 0;
    @(negedge clk);
    if (rst && imem_req_o) begin
      saw = 1;
      check("single_outstanding", 32'(pending), 32'd0);
      if (want_state == 2) begin
        check("req_after_redirect", imem_addr_o, want_addr);
        want_state = 0;
      end
      pending = 1;
      cnt     = int'($urandom_range(lat_min, lat_max));
      paddr   = imem_addr_o;
      req_log.push_back(imem_addr_o);
    end
    if (want_state == 1) want_state = 2;
  endtask

  task automatic tick_drive(input logic st, input logic b, input logic [31:0] ba);
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (pending) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(paddr);
        pending       = 0;
      end
    end
    stall_i = st;
    be_i    = b;
    baddr_i = ba;
    if (b && !st) begin
      redir_q.push_back(ba);
      want_addr  = (ba[1:0] != 2'b00) ? RST_PC : ba;
      want_state = 1;
    end
  endtask

  task automatic cycle(input logic st, input logic b, input logic [31:0] ba);
    bit saw;
    tick_sample(saw);
    tick_drive(st, b, ba);
  endtask

  task automatic wait_req();
    bit saw;
    int n;
    saw = 0;
    n   = 0;
    while (!saw && n < 20) begin
      tick_sample(saw);
      if (!saw) tick_drive(1'b0, 1'b0, 32'd0);
      n++;
    end
    check("req_seen", 32'(saw), 32'd1);
  endtask

  // Monitor: program-order model of what IF/ID must present.
  logic [31:0] exp_pc = RST_PC;
  logic        exp_fexc = 1'b0;
  logic        exp_squash = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_inst = '0;
  logic        prev_valid = 1'b0;
  int          delivered = 0;
  logic [31:0] tgt;

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_pc_o", pc_o, 32'd0);
      check("reset_inst_o", inst_o, 32'd0);
      check("reset_ctrl", 32'({valid_o, fexc_o, imem_req_o}), 32'd0);
      exp_pc     = RST_PC;
      exp_fexc   = 1'b0;
      exp_squash = 1'b0;
      stall_prev = 1'b0;
      prev_valid = 1'b0;
      redir_q.delete();
    end else begin
      check("fexc", 32'(fexc_o), 32'(exp_fexc));
      if (exp_squash) check("squash_valid", 32'(valid_o), 32'd0);
      if (stall_prev) begin
        check("stall_hold_pc", pc_o, prev_pc);
        check("stall_hold_inst", inst_o, prev_inst);
        check("stall_hold_valid", 32'(valid_o), 32'(prev_valid));
      end else if (valid_o && (!prev_valid || pc_o != prev_pc)) begin
        check("ifid_pc", pc_o, exp_pc);
        check("ifid_inst", inst_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      exp_fexc   = 1'b0;
      exp_squash = 1'b0;
      while (redir_q.size() > 0) begin
        tgt        = redir_q.pop_front();
        exp_squash = 1'b1;
        if (tgt[1:0] != 2'b00) begin
          exp_pc   = RST_PC;
          exp_fexc = 1'b1;
        end else begin
          exp_pc = tgt;
        end
      end
      stall_prev = stall_i;
      prev_pc    = pc_o;
      prev_inst  = inst_o;
      prev_valid = valid_o;
    end
  end

  logic        r_st;
  logic        r_b;
  logic [31:0] r_ba;
  int          n0;

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_initial", 32'({valid_o, fexc_o, imem_req_o}), 32'd0);
    rst = 1'b1;

    // Sequential fetch with 1-cycle memory.
    repeat (8) cycle(1'b0, 1'b0, 32'd0);
    check("seq_req_count", 32'(req_log.size() >= 4), 32'd1);
    if (req_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("seq_req_addr", req_log[i], RST_PC + 32'(4 * i));
    end

    // Stall across WAIT; response lands in the skid.
    wait_req();
    tick_drive(1'b1, 1'b0, 32'd0);
    n0 = req_log.size();
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    check("no_req_during_stall", 32'(req_log.size()), 32'(n0));
    repeat (6) cycle(1'b0, 1'b0, 32'd0);

    // Redirect while a fetch is outstanding.
    lat_min = 2;
    lat_max = 2;
    wait_req();
    tick_drive(1'b0, 1'b1, 32'h40);
    repeat (8) cycle(1'b0, 1'b0, 32'd0);
    lat_min = 1;
    lat_max = 1;

    // Redirect offered under stall is ignored, then taken.
    cycle(1'b1, 1'b1, 32'h80);
    cycle(1'b0, 1'b1, 32'h80);
    repeat (8) cycle(1'b0, 1'b0, 32'd0);

    // Misaligned target.
    cycle(1'b0, 1'b1, 32'h42);
    repeat (8) cycle(1'b0, 1'b0, 32'd0);

    // Randomized traffic.
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      r_st = ($urandom_range(0, 4) == 0);
      r_b  = ($urandom_range(0, 9) == 0);
      r_ba = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 4) == 0) r_ba[1:0] = 2'($urandom_range(1, 3));
      cycle(r_st, r_b, r_ba);
    end
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    check("progress", 32'(delivered >= 100), 32'd1);

    // Async reset mid-WAIT with a stray late response after release.
    lat_min = 3;
    lat_max = 3;
    wait_req();
    tick_drive(1'b0, 1'b0, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("async_reset_pc_o", pc_o, 32'd0);
    check("async_reset_inst_o", inst_o, 32'd0);
    check("async_reset_ctrl", 32'({valid_o, fexc_o, imem_req_o}), 32'd0);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    pending       = 0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    want_addr     = RST_PC;
    want_state    = 2;
    lat_min       = 1;
    lat_max       = 3;
    repeat (20) cycle(1'b0, 1'b0, 32'd0);
    check("first_req_after_reset_seen", 32'(want_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter and issues word fetches to instruction memory over a request/valid handshake with one outstanding request.
- Holds the IF/ID pipeline register that feeds the decode stage.
- Consumes what decode produces: the branch/jump redirect (be/baddr) and the ctrl-merged stall.
- Discards wrong-path fetches and flags misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, instruction address width.
INST_W, 32, instruction width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-low (RST_ENABLE = 1'b0).
stall_i  in  1  from ctrl (lwstall or jbstall): hold IF/ID register and PC.
be_i  in  1  branch/jump taken, from decode.
baddr_i  in  ADDR_W  branch/jump target, from decode.
imem_req_o  out  1  fetch request, one-cycle pulse per fetch.
imem_addr_o  out  ADDR_W  fetch address, valid while imem_req_o=1.
imem_rvalid_i  in  1  response valid, at least 1 cycle after the request.
imem_rdata_i  in  INST_W  fetched instruction.
pc_o  out  ADDR_W  PC of the instruction in IF/ID.
inst_o  out  INST_W  instruction in IF/ID.
valid_o  out  1  IF/ID holds a real instruction; 0 means bubble (decode sees NOP).
fexc_o  out  1  misaligned-target exception, one-cycle pulse.

Behaviour:
Reset (rst=0, async):
- pc=RESET_PC; pc_o=0; inst_o=0; valid_o=0; fexc_o=0; imem_req_o=0; state=IDLE; drop=0; skid empty.

State machine:
- IDLE: one cycle after reset release, then go to REQ.
- REQ: drive imem_req_o=1, imem_addr_o=pc; go to WAIT.
- WAIT: wait for imem_rvalid_i.
  - On rvalid with drop=0, stall_i=0: IF/ID <= {pc, rdata}, valid_o=1, pc <= pc+4 (wraps modulo 2^ADDR_W), go to REQ.
  - On rvalid with drop=0, stall_i=1: store the response in the skid register; go to HOLD.
  - On rvalid with drop=1: discard the response, clear drop, go to REQ (pc already holds the target).
- HOLD: IF/ID unchanged; no request issued. When stall_i=0: IF/ID <= skid, valid_o=1, pc <= pc+4, go to REQ.

Stall:
- While stall_i=1, IF/ID (pc_o, inst_o, valid_o) holds its value.
- A request already issued still completes, into the skid register.

Redirect:
- Accepted only when be_i=1 and stall_i=0. If stall_i=1, be_i is ignored, because decode operands may be stale.
- On accept: pc <= baddr_i; next-cycle valid_o=0 (the wrong-path slot is squashed, no delay slot).
- If in WAIT with no rvalid this cycle: set drop=1.
- If in HOLD: empty the skid, go to REQ.
- If in REQ: the request issued this cycle is to the wrong path; set drop=1 and go to WAIT.
- If rvalid arrives in the same cycle as the redirect: the response is discarded and the FSM goes to REQ with pc=baddr_i.

Misaligned target:
- If an accepted redirect has baddr_i[1:0]!=0: fexc_o=1 for one cycle, pc <= RESET_PC.
- Normal redirect handling applies (squash, drop).

Other rules:
- valid_o drops to 0 on any cycle where stall_i=0 and no new instruction is written (memory latency bubble).
- imem_rvalid_i outside WAIT is ignored.
- At most one request is outstanding; imem_req_o is never asserted in WAIT or HOLD.
- Reset asserted mid-fetch returns to IDLE; any later rvalid for the old request arrives outside WAIT and is ignored.

Test Plan:
- Sequential fetch, 1-cycle memory, RESET_PC=0: imem_addr_o sequence 0,4,8,C. pc_o/inst_o follow with valid_o=1 on every other cycle (REQ/WAIT cadence); fexc_o=0.
- Stall during WAIT: stall_i=1 for 3 cycles, response 0x2402_0005 arrives on cycle 1. IF/ID holds the old value, no new request is issued. inst_o=0x2402_0005 on the cycle after stall_i falls.
- Redirect in WAIT: be_i=1, baddr_i=0x40 while the fetch of 0x8 is outstanding. The 0x8 response is discarded; next imem_addr_o=0x40; valid_o=0 for at least one cycle; next valid inst_o has pc_o=0x40.
- be_i=1 together with stall_i=1: PC unchanged, sequential fetch resumes. Same be_i with stall_i=0 one cycle later: redirect taken.
- Misaligned target baddr_i=0x42: fexc_o pulses once; next imem_addr_o=RESET_PC.
- Async reset asserted mid-WAIT with a late rvalid after release: outputs zero immediately; the stray rvalid is ignored; first request goes to RESET_PC.
